// File: rtl/uart_cfg_rx.sv
// uart_cfg_rx: runtime-configurable UART receiver.
// Supports 5..8 data bits, none/even/odd parity and 1 or 2 stop bits.
// The clocks-per-bit divisor is also set at runtime.
// Reports parity, framing and overrun errors and rejects false start bits.
// Build option UART_RX_MAJORITY_EN: each bit is a 2-of-3 majority vote around
// the bit centre, and the decision moves one clock later.
module uart_cfg_rx #(
    parameter int clock_freq  = 100_000_000,
    parameter int limit_width = 16,
    parameter int sync_stages = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic [limit_width-1:0] baud_limit,
    input  logic [1:0]             data_bits,
    input  logic [1:0]             parity_mode,
    input  logic                   stop_bits,
    input  logic                   clr,
    output logic [7:0]             data,
    output logic                   data_rec,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    // Elaboration-time parameter sanity checks.
    if (sync_stages < 2) begin : g_bad_sync
        $error("uart_cfg_rx: sync_stages must be at least 2");
    end
    if (clock_freq <= 0) begin : g_bad_clk
        $error("uart_cfg_rx: clock_freq must be positive");
    end
    if (limit_width < 3) begin : g_bad_width
        $error("uart_cfg_rx: limit_width must be at least 3");
    end

    localparam logic [limit_width-1:0] LIM_ZERO = {limit_width{1'b0}};
    localparam logic [limit_width-1:0] LIM_ONE  = {{(limit_width-1){1'b0}}, 1'b1};
    localparam logic [limit_width-1:0] LIM_MIN  = {{(limit_width-3){1'b0}}, 3'b100};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_COMPLETE = 3'd5
    } state_t;

    // Parity error for the received word: even mode flags odd total ones,
    // odd mode flags even total ones, other modes never flag.
    function automatic logic parity_error(input logic [7:0] word,
                                          input logic       p,
                                          input logic [1:0] mode);
        logic result;
        case (mode)
            2'd1:    result = (^word) ^ p;
            2'd2:    result = ~((^word) ^ p);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    logic [sync_stages-1:0] sync_r;
    logic                   rxs_s;

    state_t                 state_r;
    logic [limit_width-1:0] lim_r;
    logic [1:0]             nbits_r;
    logic [1:0]             par_r;
    logic                   stop2_r;
    logic [limit_width-1:0] cnt_r;
    logic [2:0]             bit_idx_r;
    logic                   stop_idx_r;
    logic [7:0]             shift_r;
    logic                   par_err_r;
    logic                   frm_err_r;
    logic                   armed_r;

    logic [7:0]             data_r;
    logic                   data_rec_r;
    logic                   parity_err_r;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic                   busy_r;

    logic [limit_width-1:0] half_s;
    logic                   wrap_s;
    logic [limit_width-1:0] cnt_next_s;
    logic                   decide_s;
    logic                   bit_s;
    logic [2:0]             last_idx_s;
    logic                   par_en_s;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {sync_stages{1'b1}};
        end else begin
            sync_r <= {sync_r[sync_stages-2:0], rx};
        end
    end

    assign rxs_s      = sync_r[sync_stages-1];
    assign half_s     = lim_r >> 1;
    assign wrap_s     = (cnt_r == (lim_r - LIM_ONE));
    assign cnt_next_s = wrap_s ? LIM_ZERO : (cnt_r + LIM_ONE);
    assign last_idx_s = {1'b0, nbits_r} + 3'd4;
    assign par_en_s   = (par_r == 2'd1) || (par_r == 2'd2);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early_r;

    // 2-of-3 vote used to reject single-clock glitches near the bit centre.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the two samples that precede the decision clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            early_r <= 2'b11;
        end else begin
            if (cnt_r == (half_s - LIM_ONE)) begin
                early_r[0] <= rxs_s;
            end
            if (cnt_r == half_s) begin
                early_r[1] <= rxs_s;
            end
        end
    end

    assign decide_s = (cnt_r == (half_s + LIM_ONE));
    assign bit_s    = majority3(early_r[0], early_r[1], rxs_s);
`else
    assign decide_s = (cnt_r == half_s);
    assign bit_s    = rxs_s;
`endif

    // Receive state machine, config latch and registered consumer outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            lim_r        <= LIM_MIN;
            nbits_r      <= 2'd3;
            par_r        <= 2'd0;
            stop2_r      <= 1'b0;
            cnt_r        <= LIM_ZERO;
            bit_idx_r    <= 3'd0;
            stop_idx_r   <= 1'b0;
            shift_r      <= 8'h00;
            par_err_r    <= 1'b0;
            frm_err_r    <= 1'b0;
            armed_r      <= 1'b1;
            data_r       <= 8'h00;
            data_rec_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Consumer acknowledge; a completing frame takes priority below.
            if (clr && (state_r != S_COMPLETE)) begin
                data_rec_r <= 1'b0;
                overrun_r  <= 1'b0;
            end

            case (state_r)
                S_IDLE: begin
                    busy_r <= 1'b0;
                    if (!armed_r) begin
                        // After a break, wait for the line to return high.
                        if (rxs_s) begin
                            armed_r <= 1'b1;
                        end
                    end else if (!rxs_s) begin
                        state_r    <= S_START;
                        busy_r     <= 1'b1;
                        cnt_r      <= LIM_ZERO;
                        lim_r      <= (baud_limit < LIM_MIN) ? LIM_MIN : baud_limit;
                        nbits_r    <= data_bits;
                        par_r      <= parity_mode;
                        stop2_r    <= stop_bits;
                        bit_idx_r  <= 3'd0;
                        stop_idx_r <= 1'b0;
                        shift_r    <= 8'h00;
                        par_err_r  <= 1'b0;
                        frm_err_r  <= 1'b0;
                    end
                end

                S_START: begin
                    cnt_r <= cnt_next_s;
                    if (decide_s && bit_s) begin
                        // Line was high at the centre: treat as a glitch.
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else if (wrap_s) begin
                        state_r <= S_DATA;
                    end
                end

                S_DATA: begin
                    cnt_r <= cnt_next_s;
                    if (decide_s) begin
                        shift_r[bit_idx_r] <= bit_s;
                    end
                    if (wrap_s) begin
                        if (bit_idx_r == last_idx_s) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= par_en_s ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end

                S_PARITY: begin
                    cnt_r <= cnt_next_s;
                    if (decide_s) begin
                        par_err_r <= parity_error(shift_r, bit_s, par_r);
                    end
                    if (wrap_s) begin
                        state_r <= S_STOP;
                    end
                end

                S_STOP: begin
                    cnt_r <= cnt_next_s;
                    if (decide_s) begin
                        if (!bit_s) begin
                            frm_err_r <= 1'b1;
                        end
                        if (stop2_r && !stop_idx_r) begin
                            stop_idx_r <= 1'b1;
                        end else begin
                            // Complete mid stop bit so a following start
                            // bit with zero idle time is still caught.
                            state_r <= S_COMPLETE;
                            armed_r <= bit_s;
                        end
                    end
                end

                S_COMPLETE: begin
                    data_r       <= shift_r;
                    parity_err_r <= par_err_r;
                    frame_err_r  <= frm_err_r;
                    data_rec_r   <= 1'b1;
                    overrun_r    <= overrun_r | data_rec_r;
                    state_r      <= S_IDLE;
                    busy_r       <= 1'b0;
                end

                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_r;
    assign data_rec   = data_rec_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: doc/uart_cfg_rx.md
Name: uart_cfg_rx

Overview:
- Runtime-configurable UART receiver; successor to the fixed 8N1 receiver.
- Baud divisor, data length, parity and stop-bit count are all set at runtime.
- Reports parity, framing and overrun errors, and rejects false start bits.
- Sits between the board RX pin (after the pad) and the command parser; data_rec/clr handshake with the consumer is unchanged.

Parameters:
- clock_freq, 100_000_000, system clock in Hz (documentation/default-divisor use only).
- limit_width, 16, width of baud_limit and of the internal baud counter.
- sync_stages, 2, number of rx synchroniser flops (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- baud_limit  input  limit_width  clocks per bit; values <4 are treated as 4.
- data_bits  input  2  word length: 0=5, 1=6, 2=7, 3=8.
- parity_mode  input  2  0=none, 1=even, 2=odd, 3=none.
- stop_bits  input  1  0=one stop bit, 1=two stop bits.
- clr  input  1  consumer acknowledge; clears data_rec and overrun.
- data  output  8  received word, LSB-aligned, unused MSBs zero.
- data_rec  output  1  sticky "word available".
- parity_err  output  1  parity mismatch on latest word.
- frame_err  output  1  a stop bit sampled low on latest word.
- overrun  output  1  sticky; a word completed while data_rec=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: data=8'h00, data_rec=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchroniser flops=1.
- rx passes through sync_stages flops; all logic uses the synchronised value rxs.
- Config latch: baud_limit, data_bits, parity_mode and stop_bits are captured on the IDLE→START transition. Config changes mid-frame take effect on the next frame.
- Baud counter runs 0..L-1 (L = latched limit) and wraps.
- Sample point is cnt == L>>1. The bit advance is the wrap.
- States and transitions:
  - IDLE: rxs=0 → START, counter cleared to 0.
  - START: at the sample point, rxs=1 → IDLE (false start, nothing reported). Otherwise continue; at the wrap → DATA.
  - DATA: sample each bit LSB-first into a shift register. After N bits (N=5..8) → PARITY if parity is enabled, else → STOP.
  - PARITY: sample p. Error condition: even mode, XOR(data, p)=1; odd mode, XOR(data, p)=0.
  - STOP: sample stop bit 1. If stop_bits=1, wrap, then sample stop bit 2. Any low sample sets the frame error.
  - COMPLETE: one cycle after the final stop sample (not at its wrap). Updates outputs, then → IDLE. This allows back-to-back frames with zero idle time.
- At COMPLETE:
  - data ← word.
  - parity_err and frame_err ← this frame's results (0 when parity is off).
  - data_rec ← 1.
  - overrun ← 1 if data_rec was already 1.
- Latency: data_rec rises sync_stages+1 cycles after the mid-sample of the last stop bit, measured from the rx pin.
- clr in the same cycle as COMPLETE: COMPLETE wins, data_rec stays 1. Overrun is then evaluated on the pre-clr data_rec.
- clr otherwise: data_rec←0 and overrun←0. Error flags hold until the next COMPLETE.
- A frame with errors still delivers data and asserts data_rec.
- rx held low (break) gives data=0 and frame_err=1. The receiver then waits in IDLE for rxs to return to 1 before arming the next start detect.
- Asynchronous rst at any point aborts the frame and returns all outputs to reset values immediately.

Optional Feature:
- UART_RX_MAJORITY_EN defined: each bit (start, data, parity, stop) is the 2-of-3 majority of rxs at cnt = (L>>1)-1, L>>1 and (L>>1)+1. Decision is at (L>>1)+1; all latencies grow by 1 cycle.
- Undefined: single sample at L>>1, no extra flops.

Test Plan:
- Basic 8N1: L=868, data_bits=3, parity 0, stop 0, send 0xA5 → data=0xA5, data_rec=1, all error flags 0, busy low after COMPLETE.
- 7E2: L=16, data_bits=2, parity 1, stop 1, send 0x35 with correct parity, then 0x35 with flipped parity bit → first frame parity_err=0; second data=0x35, parity_err=1.
- Framing error plus false start:
  - Stop bit driven low (L=16, 8N1, 0x3C) → data=0x3C, frame_err=1.
  - A 5-clock low glitch on idle rx → no data_rec and state back to IDLE.
- Overrun / clr race: two back-to-back 0x11, 0x22 without clr → data=0x22, overrun=1.
  - clr coincident with the second COMPLETE → data_rec=1, overrun=1.
  - clr one cycle later → both 0.
- Reset mid-frame plus config change: assert rst during bit 4 of 0xFF → outputs reset, busy=0.
  - Change baud_limit 16→32 mid-frame → current frame still decodes at 16, next frame at 32.
- With UART_RX_MAJORITY_EN: 1-clock inverted glitch at the sample point of every data bit of 0x5A (L=16) → data=0x5A, no errors.
